// File: rtl/carpark_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : carpark_gate_ctrl_if
// Brief    : Lane sensor / actuator / status bundle for carpark_gate_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface carpark_gate_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             exit_req;
    logic             car_pass;
    logic             gate_open;
    logic             dir;
    logic             entry_grant;
    logic             exit_grant;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             timeout;

    // master = sensors/display side, slave = the gate controller
    modport master (
        output entry_req, exit_req, car_pass,
        input  gate_open, dir, entry_grant, exit_grant, occupancy, full, empty, timeout
    );

    modport slave (
        input  entry_req, exit_req, car_pass,
        output gate_open, dir, entry_grant, exit_grant, occupancy, full, empty, timeout
    );
endinterface
`default_nettype wire

// File: rtl/carpark_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : carpark_gate_ctrl
// Brief    : Shared entry/exit lane sequencer with round-robin arbitration,
//            gate open/close cycle and occupancy count.
//            Optional gate-open timeout: define CARPARK_GATE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module carpark_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    carpark_gate_ctrl_if.slave lane
);

    if (CAPACITY < 1 || CAPACITY >= (1 << CNT_W) || OPEN_CYCLES < 1) begin : g_bad_params
        $error("carpark_gate_ctrl: invalid CAPACITY/CNT_W/OPEN_CYCLES");
    end

    localparam logic [CNT_W-1:0] c_capacity = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_gate_open;
    logic             r_dir;
    logic             r_entry_grant;
    logic             r_exit_grant;
    logic [CNT_W-1:0] r_occupancy;
    logic             r_full;
    logic             r_empty;
    logic             r_rr_entry;

    state_t           w_state_nxt;
    logic             w_gate_nxt;
    logic             w_dir_nxt;
    logic             w_entry_grant_nxt;
    logic             w_exit_grant_nxt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_rr_nxt;

    logic w_entry_ok;
    logic w_exit_ok;
    logic w_pick_entry;

    assign w_entry_ok   = lane.entry_req && (r_occupancy < c_capacity);
    assign w_exit_ok    = lane.exit_req && (r_occupancy != '0);
    assign w_pick_entry = w_entry_ok && (!w_exit_ok || r_rr_entry);

`ifdef CARPARK_GATE_TIMEOUT_EN
    localparam int                 c_tmr_w    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(OPEN_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);

    logic [c_tmr_w-1:0] r_open_cnt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               w_expired;

    assign w_expired    = (r_open_cnt == c_tmr_last);
    assign lane.timeout = r_timeout;
`else
    assign lane.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gate_open   <= 1'b0;
            r_dir         <= 1'b0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_occupancy   <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_rr_entry    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gate_open   <= w_gate_nxt;
            r_dir         <= w_dir_nxt;
            r_entry_grant <= w_entry_grant_nxt;
            r_exit_grant  <= w_exit_grant_nxt;
            r_occupancy   <= w_occ_nxt;
            r_full        <= (w_occ_nxt == c_capacity);
            r_empty       <= (w_occ_nxt == '0);
            r_rr_entry    <= w_rr_nxt;
        end
`ifdef CARPARK_GATE_TIMEOUT_EN
        // Counts edges spent in OPEN; restarts from zero on every new opening.
        if (rst || r_state != OPEN) begin
            r_open_cnt <= '0;
        end else begin
            r_open_cnt <= r_open_cnt + c_tmr_one;
        end
        r_timeout <= rst ? 1'b0 : w_timeout_nxt;
`endif
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_gate_nxt        = r_gate_open;
        w_dir_nxt         = r_dir;
        w_entry_grant_nxt = 1'b0;
        w_exit_grant_nxt  = 1'b0;
        w_occ_nxt         = r_occupancy;
        w_rr_nxt          = r_rr_entry;
`ifdef CARPARK_GATE_TIMEOUT_EN
        w_timeout_nxt     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // The pointer flips after every grant, contested or not.
                if (w_pick_entry) begin
                    w_state_nxt       = OPEN;
                    w_gate_nxt        = 1'b1;
                    w_dir_nxt         = 1'b1;
                    w_entry_grant_nxt = 1'b1;
                    w_rr_nxt          = 1'b0;
                end else if (w_exit_ok) begin
                    w_state_nxt      = OPEN;
                    w_gate_nxt       = 1'b1;
                    w_dir_nxt        = 1'b0;
                    w_exit_grant_nxt = 1'b1;
                    w_rr_nxt         = 1'b1;
                end
            end
            OPEN: begin
                if (lane.car_pass) begin
                    if (r_dir) begin
                        if (r_occupancy < c_capacity) begin
                            w_occ_nxt = r_occupancy + c_one;
                        end
                    end else if (r_occupancy != '0) begin
                        w_occ_nxt = r_occupancy - c_one;
                    end
                    w_gate_nxt  = 1'b0;
                    w_state_nxt = CLOSING;
                end
`ifdef CARPARK_GATE_TIMEOUT_EN
                else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_gate_nxt    = 1'b0;
                    w_state_nxt   = CLOSING;
                end
`endif
            end
            CLOSING: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gate_nxt  = 1'b0;
            end
        endcase
    end

    assign lane.gate_open   = r_gate_open;
    assign lane.dir         = r_dir;
    assign lane.entry_grant = r_entry_grant;
    assign lane.exit_grant  = r_exit_grant;
    assign lane.occupancy   = r_occupancy;
    assign lane.full        = r_full;
    assign lane.empty       = r_empty;

endmodule
`default_nettype wire

// File: doc/carpark_gate_ctrl.md
Name: carpark_gate_ctrl

Overview:
Sequencing controller for a single shared entry/exit lane of the car park. Arbitrates between the entry and exit requesters and grants the lane to one of them. Drives the gate open/close cycle and keeps the occupancy count. Produces full/empty status for the display and slot-availability logic downstream.

Parameters:
CAPACITY, 8, maximum number of parked cars (1..2^CNT_W-1)
CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY
OPEN_CYCLES, 16, gate-open timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
entry_req  input  1  level; car waiting at entry sensor
exit_req  input  1  level; car waiting at exit sensor
car_pass  input  1  one-cycle pulse; car has fully cleared the gate
gate_open  output  1  gate actuator; 1 = open
dir  output  1  lane direction of the current/last grant; 1 = entry, 0 = exit
entry_grant  output  1  one-cycle pulse when entry is granted
exit_grant  output  1  one-cycle pulse when exit is granted
occupancy  output  CNT_W  current parked-car count
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0
timeout  output  1  one-cycle pulse on gate timeout (0 when the feature is compiled out)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- All outputs and state are registered.
- Reset values: state IDLE, gate_open=0, dir=0, grants=0, occupancy=0, full=0, empty=1, timeout=0, round-robin pointer favours exit.
- Reset asserted mid-transaction: aborts the transaction, closes the gate, clears occupancy to 0 and returns to IDLE on that edge.
- FSM states: IDLE, OPEN, CLOSING.
- Eligibility in IDLE:
  - entry is eligible if entry_req=1 and occupancy < CAPACITY.
  - exit is eligible if exit_req=1 and occupancy > 0.
- Arbitration:
  - If exactly one requester is eligible, it wins.
  - If both are eligible, the round-robin pointer decides; after each grant the pointer moves to favour the other direction.
  - If neither is eligible, stay in IDLE.
  - An entry request while full is held off indefinitely and is never granted.
- IDLE -> OPEN, on the edge where a winner exists:
  - set dir to the winner.
  - pulse the matching grant for exactly 1 cycle.
  - set gate_open=1 (visible the cycle after the request is sampled).
- OPEN:
  - gate_open stays 1; requests are ignored.
  - On car_pass=1: occupancy +1 if dir=1, -1 if dir=0; full/empty updated on the same edge; gate_open=0; go to CLOSING.
- CLOSING: one cycle with gate_open=0, then IDLE.
  - Minimum transaction: 3 cycles from grant to the next possible grant.
- car_pass in IDLE or CLOSING is ignored; occupancy is unchanged.
- Occupancy never wraps:
  - entry is never granted at CAPACITY and exit is never granted at 0, so the counter stays in 0..CAPACITY.
  - Saturating guards are still required in the update logic.
- A request deasserted while in OPEN does not close the gate; only car_pass (or timeout) does.

Optional Feature:
Macro: CARPARK_GATE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in OPEN.
  - If car_pass has not arrived after OPEN_CYCLES cycles in OPEN, pulse timeout for 1 cycle, set gate_open=0 and go to CLOSING; occupancy is unchanged.
  - If car_pass arrives on the same cycle the count expires, car_pass takes priority: normal count update, no timeout pulse.
- Undefined: no counter is built, timeout is tied to 0, and OPEN waits for car_pass indefinitely.

Test Plan:
1. Reset then idle: rst high 2 cycles -> occupancy=0, empty=1, full=0, gate_open=0; an exit_req alone is never granted.
2. Single entry: entry_req=1 at occupancy 0 -> entry_grant pulse, dir=1, gate_open=1 next cycle; car_pass -> occupancy=1, empty=0, gate_open=0, one cycle of CLOSING, then IDLE.
3. Fill to capacity: 8 entry transactions -> occupancy=8, full=1; a 9th entry_req held 20 cycles -> no grant, gate stays closed.
4. Simultaneous requests: occupancy=3, entry_req and exit_req held together for 4 transactions -> grants alternate exit, entry, exit, entry; occupancy ends at 3.
5. Reset mid-transaction: occupancy=5, in OPEN with dir=1, rst asserted -> next cycle gate_open=0, occupancy=0, state IDLE; a car_pass in that cycle has no effect.
6. Timeout (CARPARK_GATE_TIMEOUT_EN defined, OPEN_CYCLES=16): grant entry, no car_pass -> timeout pulse after 16 cycles in OPEN, gate_open=0, occupancy unchanged. With car_pass on cycle 16 -> count update and no timeout pulse.
